register_right_seq: RTL and testbench

- Clocked shift-right register; the right-shift counterpart of the left shift register in the Register library.
- Controlled by the library's req/fin handshake:
  - rising saveReq loads `in`;
  - rising rightReq shifts `out` right by `shamt` bits, one bit per clock, logical or arithmetic.
- Used where datapath blocks need right shifts (dividers, normalisers) inside the synchronous domain.

---
 rtl/register_right_seq.sv | 112 +++++++++++
 tb/tb_register_right_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_right_seq.sv
// Sequential right-shift register driven by the Register library's req/fin handshake.
// A rising saveReq loads `in`; a rising rightReq shifts `out` right one bit per clock.
module register_right_seq #(
  parameter int Width = 32,
  parameter int ShW   = $clog2(Width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             saveReq,
  output logic             saveFin,
  input  logic             rightReq,
  output logic             rightFin,
  input  logic [ShW-1:0]   shamt,
  input  logic             arith,
  input  logic [Width-1:0] in,
  output logic [Width-1:0] out,
  output logic             busy
);

  // Handshake: a request is a 0->1 transition of saveReq/rightReq seen at a clock
  // edge; its fin drops on that edge and rises again on the edge the work completes.
  typedef enum logic {IDLE, SHIFT} stateT;

  stateT          state;
  stateT          stateNext;
  logic           saveQ;
  logic           rightQ;
  logic           savePend;
  logic           rightPend;
  logic [ShW-1:0] pendAmt;
  logic           pendArith;
  logic [ShW-1:0] cnt;
  logic           mode;
  logic           saveRise;
  logic           rightRise;
  logic           fill;

  assign saveRise  = saveReq & ~saveQ;
  assign rightRise = rightReq & ~rightQ;
  assign fill      = mode & out[Width-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (rightPend && (pendAmt != '0)) stateNext = SHIFT;
      SHIFT: if (cnt == ShW'(1))               stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT) | savePend | rightPend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      saveFin   <= 1'b0;
      rightFin  <= 1'b0;
      saveQ     <= 1'b0;
      rightQ    <= 1'b0;
      savePend  <= 1'b0;
      rightPend <= 1'b0;
      pendAmt   <= '0;
      pendArith <= 1'b0;
      cnt       <= '0;
      mode      <= 1'b0;
    end else begin
      saveQ  <= saveReq;
      rightQ <= rightReq;
      case (state)
        IDLE: begin
          if (savePend) begin
            out      <= in;
            savePend <= 1'b0;
            saveFin  <= 1'b1;
          end
          // A pending shift is dispatched alongside a load so it starts on the next edge.
          if (rightPend) begin
            cnt       <= pendAmt;
            mode      <= pendArith;
            rightPend <= 1'b0;
            if (pendAmt == '0) rightFin <= 1'b1;
          end
        end
        SHIFT: begin
          out <= {fill, out[Width-1:1]};
          cnt <= cnt - ShW'(1);
          if (cnt == ShW'(1)) rightFin <= 1'b1;
        end
        default: ;
      endcase
      // New requests override the completion writes above on the same edge.
      if (saveRise) begin
        saveFin  <= 1'b0;
        savePend <= 1'b1;
      end
      if (rightRise) begin
        rightFin  <= 1'b0;
        rightPend <= 1'b1;
        pendAmt   <= shamt;
        pendArith <= arith;
      end
    end
  end

endmodule

// File: tb/tb_register_right_seq.sv
// Bench for register_right_seq at Width=8: directed scenarios plus randomized
// load/shift sequences checked against a plain-arithmetic reference model.
module tb_register_right_seq;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          save_req;
  logic          save_fin;
  logic          right_req;
  logic          right_fin;
  logic [SW-1:0] shamt;
  logic          arith;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          busy;

  int n_checks;
  int n_pass;

  register_right_seq #(.Width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .saveReq  (save_req),
    .saveFin  (save_fin),
    .rightReq (right_req),
    .rightFin (right_fin),
    .shamt    (shamt),
    .arith    (arith),
    .in       (din),
    .out      (dout),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: whole-word right shift by n places
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] v, int n, logic ar);
    logic signed [W-1:0] sv;
    sv = v;
    if (ar) return W'(sv >>> n);
    return v >> n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_save(input logic [W-1:0] data);
    din = data;
    save_req = 1'b1;
    tick();
    tick();
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    save_req = 1'b0;
    right_req = 1'b0;
    shamt = '0;
    arith = 1'b0;
    din = '0;
    tick();
    tick();
    n_checks++; if (dout !== 8'h00) $display("FAIL reset_out got %h want 00", dout); else n_pass++;
    n_checks++; if (save_fin !== 1'b0) $display("FAIL reset_save_fin got %b want 0", save_fin); else n_pass++;
    n_checks++; if (right_fin !== 1'b0) $display("FAIL reset_right_fin got %b want 0", right_fin); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    din = 8'hB4;
    save_req = 1'b1;
    tick(); // E0
    n_checks++; if (save_fin !== 1'b0) $display("FAIL load_fin_e0 got %b want 0", save_fin); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL load_busy_e0 got %b want 1", busy); else n_pass++;
    tick(); // E1
    n_checks++; if (dout !== 8'hB4) $display("FAIL load_out got %h want b4", dout); else n_pass++;
    n_checks++; if (save_fin !== 1'b1) $display("FAIL load_fin_e1 got %b want 1", save_fin); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL load_busy_e1 got %b want 0", busy); else n_pass++;
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_logical();
    logic [W-1:0] exp_out [3];
    exp_out[0] = 8'h5A;
    exp_out[1] = 8'h2D;
    exp_out[2] = 8'h16;
    shamt = 3'd3;
    arith = 1'b0;
    right_req = 1'b1;
    tick(); // E0
    n_checks++; if (right_fin !== 1'b0) $display("FAIL lsr_fin_e0 got %b want 0", right_fin); else n_pass++;
    tick(); // E1
    n_checks++; if (dout !== 8'hB4) $display("FAIL lsr_out_e1 got %h want b4", dout); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (dout !== exp_out[k]) $display("FAIL lsr_out_e%0d got %h want %h", k + 2, dout, exp_out[k]);
      else n_pass++;
      n_checks++;
      if (right_fin !== (k == 2)) $display("FAIL lsr_fin_e%0d got %b want %b", k + 2, right_fin, k == 2);
      else n_pass++;
    end
    n_checks++; if (save_fin !== 1'b1) $display("FAIL lsr_save_fin_kept got %b want 1", save_fin); else n_pass++;
    right_req = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    do_save(8'hB4);
    shamt = 3'd2;
    arith = 1'b1;
    right_req = 1'b1;
    tick(); // E0
    tick(); // E1
    tick(); // E2
    n_checks++; if (dout !== 8'hDA) $display("FAIL asr_out_e2 got %h want da", dout); else n_pass++;
    n_checks++; if (right_fin !== 1'b0) $display("FAIL asr_fin_e2 got %b want 0", right_fin); else n_pass++;
    tick(); // E3
    n_checks++; if (dout !== 8'hED) $display("FAIL asr_out_e3 got %h want ed", dout); else n_pass++;
    n_checks++; if (right_fin !== 1'b1) $display("FAIL asr_fin_e3 got %b want 1", right_fin); else n_pass++;
    right_req = 1'b0;
    tick();
    shamt = 3'd0;
    right_req = 1'b1;
    tick(); // E0
    n_checks++; if (right_fin !== 1'b0) $display("FAIL zero_fin_e0 got %b want 0", right_fin); else n_pass++;
    tick(); // E1
    n_checks++; if (dout !== 8'hED) $display("FAIL zero_out got %h want ed", dout); else n_pass++;
    n_checks++; if (right_fin !== 1'b1) $display("FAIL zero_fin_e1 got %b want 1", right_fin); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b want 0", busy); else n_pass++;
    right_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    din = 8'h80;
    shamt = 3'd1;
    arith = 1'b1;
    save_req = 1'b1;
    right_req = 1'b1;
    tick(); // E0
    n_checks++; if ({save_fin, right_fin} !== 2'b00) $display("FAIL both_fins_e0 got %b want 00", {save_fin, right_fin}); else n_pass++;
    tick(); // E1
    n_checks++; if (dout !== 8'h80) $display("FAIL both_out_e1 got %h want 80", dout); else n_pass++;
    n_checks++; if ({save_fin, right_fin} !== 2'b10) $display("FAIL both_fins_e1 got %b want 10", {save_fin, right_fin}); else n_pass++;
    tick(); // E2
    n_checks++; if (dout !== 8'hC0) $display("FAIL both_out_e2 got %h want c0", dout); else n_pass++;
    n_checks++; if (right_fin !== 1'b1) $display("FAIL both_fin_e2 got %b want 1", right_fin); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL both_busy_e2 got %b want 0", busy); else n_pass++;
    save_req = 1'b0;
    right_req = 1'b0;
    tick();
  endtask

  task automatic test_save_during_shift();
    // out is 0xC0 here; `in` already carries the new value so an early load would show
    din = 8'h0F;
    shamt = 3'd5;
    arith = 1'b0;
    right_req = 1'b1;
    tick(); // E0
    tick(); // E1
    tick(); // E2
    save_req = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      tick();
      n_checks++;
      if (dout !== ref_shift(8'hC0, c - 1, 1'b0))
        $display("FAIL sds_out_e%0d got %h want %h", c, dout, ref_shift(8'hC0, c - 1, 1'b0));
      else n_pass++;
      n_checks++;
      if (right_fin !== (c == 6)) $display("FAIL sds_rfin_e%0d got %b want %b", c, right_fin, c == 6);
      else n_pass++;
    end
    n_checks++; if (save_fin !== 1'b0) $display("FAIL sds_sfin_e6 got %b want 0", save_fin); else n_pass++;
    tick(); // E7
    n_checks++; if (dout !== 8'h0F) $display("FAIL sds_out_e7 got %h want 0f", dout); else n_pass++;
    n_checks++; if (save_fin !== 1'b1) $display("FAIL sds_sfin_e7 got %b want 1", save_fin); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL sds_busy_e7 got %b want 0", busy); else n_pass++;
    save_req = 1'b0;
    right_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    do_save(8'hF0);
    shamt = 3'd6;
    arith = 1'b1;
    right_req = 1'b1;
    tick(); // E0
    tick(); // E1
    tick(); // E2
    tick(); // E3: two shifts done
    n_checks++; if (dout !== 8'hFC) $display("FAIL rms_out_pre got %h want fc", dout); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (dout !== 8'h00) $display("FAIL rms_out got %h want 00", dout); else n_pass++;
    n_checks++; if (right_fin !== 1'b0) $display("FAIL rms_fin got %b want 0", right_fin); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rms_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    tick(); // E0: held request counts as a rise
    n_checks++; if (busy !== 1'b1) $display("FAIL rms_busy_e0 got %b want 1", busy); else n_pass++;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_checks++;
      if (right_fin !== (c == 7)) $display("FAIL rms_fin_e%0d got %b want %b", c, right_fin, c == 7);
      else n_pass++;
    end
    right_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] orig;
    logic [W-1:0] data;
    int amt;
    logic ar;
    for (int it = 0; it < 20; it++) begin
      data = W'($urandom_range(0, 255));
      amt  = $urandom_range(0, 7);
      ar   = 1'($urandom_range(0, 1));
      do_save(data);
      n_checks++;
      if (dout !== data) $display("FAIL rnd_load_%0d got %h want %h", it, dout, data); else n_pass++;
      orig = data;
      exp_q.delete();
      exp_q.push_back(orig);
      for (int s = 1; s <= amt; s++) exp_q.push_back(ref_shift(orig, s, ar));
      shamt = SW'(amt);
      arith = ar;
      right_req = 1'b1;
      tick(); // E0
      for (int c = 1; c <= amt + 1; c++) begin
        logic [W-1:0] e;
        tick();
        e = (c == 1) ? exp_q[0] : exp_q[c - 1];
        n_checks++;
        if (dout !== e) $display("FAIL rnd_out_%0d_e%0d got %h want %h", it, c, dout, e); else n_pass++;
        n_checks++;
        if (right_fin !== (c == amt + 1))
          $display("FAIL rnd_fin_%0d_e%0d got %b want %b", it, c, right_fin, c == amt + 1);
        else n_pass++;
      end
      n_checks++;
      if (dout !== ref_shift(data, amt, ar))
        $display("FAIL rnd_final_%0d got %h want %h", it, dout, ref_shift(data, amt, ar));
      else n_pass++;
      right_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_load();
    test_logical();
    test_arith();
    test_back_to_back();
    test_save_during_shift();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
